// File: rtl/y86_pkg.sv
// Shared Y86 encodings and types for the decode stage and its register file.
package y86_pkg;

    typedef logic [3:0]  reg_id_t;
    typedef logic [31:0] word_t;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVL = 4'h2;
    localparam logic [3:0] ICODE_IRMOVL = 4'h3;
    localparam logic [3:0] ICODE_RMMOVL = 4'h4;
    localparam logic [3:0] ICODE_MRMOVL = 4'h5;
    localparam logic [3:0] ICODE_OPL    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHL  = 4'hA;
    localparam logic [3:0] ICODE_POPL   = 4'hB;

    localparam reg_id_t REG_ESP  = 4'h4;
    localparam reg_id_t REG_NONE = 4'hF;

    // Only IDs 0..7 name real registers; 8..F read as zero and never write.
    function automatic logic is_gpr(reg_id_t id);
        return (id[3] == 1'b0);
    endfunction

endpackage

// File: rtl/y86_decode_if.sv
// Fetch-side, execute-side and writeback signals of the decode stage.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never depends on ready, and the producer holds data while stalled.
interface y86_decode_if #(parameter int DATA_W = 32);
    import y86_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_icode;
    logic [3:0]        in_ifun;
    reg_id_t           in_rA;
    reg_id_t           in_rB;
    logic [DATA_W-1:0] in_valC;
    logic [DATA_W-1:0] in_valP;

    reg_id_t           wb_dstE;
    logic [DATA_W-1:0] wb_valE;
    reg_id_t           wb_dstM;
    logic [DATA_W-1:0] wb_valM;
    logic              flush;

    logic              out_valid;
    logic              out_ready;
    logic [3:0]        out_icode;
    logic [3:0]        out_ifun;
    logic [DATA_W-1:0] out_valC;
    logic [DATA_W-1:0] out_valP;
    logic [DATA_W-1:0] out_valA;
    logic [DATA_W-1:0] out_valB;
    reg_id_t           out_srcA;
    reg_id_t           out_srcB;
    reg_id_t           out_dstE;
    reg_id_t           out_dstM;
    logic              halted;
    logic              err;

    modport master (
        output in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP,
        output wb_dstE, wb_valE, wb_dstM, wb_valM, flush, out_ready,
        input  in_ready, out_valid, out_icode, out_ifun, out_valC, out_valP,
        input  out_valA, out_valB, out_srcA, out_srcB, out_dstE, out_dstM,
        input  halted, err
    );

    modport slave (
        input  in_valid, in_icode, in_ifun, in_rA, in_rB, in_valC, in_valP,
        input  wb_dstE, wb_valE, wb_dstM, wb_valM, flush, out_ready,
        output in_ready, out_valid, out_icode, out_ifun, out_valC, out_valP,
        output out_valA, out_valB, out_srcA, out_srcB, out_dstE, out_dstM,
        output halted, err
    );

endinterface

// File: rtl/y86_regfile.sv
// 8x32 architectural register file: two bypassed read ports, two write ports
// where M wins over E when both target the same register.
module y86_regfile
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] ESP_INIT = 32'h0000_0400
) (
    input  logic              clock,
    input  logic              reset_n,
    input  reg_id_t           rd_a_id,
    output logic [DATA_W-1:0] rd_a_data,
    input  reg_id_t           rd_b_id,
    output logic [DATA_W-1:0] rd_b_data,
    input  reg_id_t           wr_e_id,
    input  logic [DATA_W-1:0] wr_e_data,
    input  reg_id_t           wr_m_id,
    input  logic [DATA_W-1:0] wr_m_data
);

    logic [DATA_W-1:0] regs [8];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= (i == int'(REG_ESP)) ? ESP_INIT : '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (is_gpr(wr_m_id) && wr_m_id[2:0] == 3'(i)) begin
                    regs[i] <= wr_m_data;
                end else if (is_gpr(wr_e_id) && wr_e_id[2:0] == 3'(i)) begin
                    regs[i] <= wr_e_data;
                end
            end
        end
    end

    // Same-cycle writes are forwarded so a capture sees the value being committed.
    always_comb begin
        rd_a_data = '0;
        if (is_gpr(rd_a_id)) begin
            if (wr_m_id == rd_a_id)      rd_a_data = wr_m_data;
            else if (wr_e_id == rd_a_id) rd_a_data = wr_e_data;
            else                         rd_a_data = regs[rd_a_id[2:0]];
        end
    end

    always_comb begin
        rd_b_data = '0;
        if (is_gpr(rd_b_id)) begin
            if (wr_m_id == rd_b_id)      rd_b_data = wr_m_data;
            else if (wr_e_id == rd_b_id) rd_b_data = wr_e_data;
            else                         rd_b_data = regs[rd_b_id[2:0]];
        end
    end

endmodule

// File: rtl/y86_decode.sv
// Y86 decode stage: derives register IDs, reads operands and holds the result
// in a single output register for execute; freezes after halt or illegal icode.
module y86_decode
    import y86_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] ESP_INIT = 32'h0000_0400
) (
    input logic        clock,
    input logic        reset_n,
    y86_decode_if.slave bus
);

    reg_id_t           src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] rd_a, rd_b;
    logic [DATA_W-1:0] ref_a, ref_b;
    logic              capture, out_from_p;

    logic              out_valid_q, halted_q, err_q;
    logic [3:0]        icode_q, ifun_q;
    logic [DATA_W-1:0] valc_q, valp_q, vala_q, valb_q;
    reg_id_t           srca_q, srcb_q, dste_q, dstm_q;

    always_comb begin
        src_a = REG_NONE;
        src_b = REG_NONE;
        dst_e = REG_NONE;
        dst_m = REG_NONE;
        case (bus.in_icode)
            ICODE_RRMOVL, ICODE_RMMOVL, ICODE_OPL, ICODE_PUSHL: src_a = bus.in_rA;
            ICODE_RET, ICODE_POPL:                              src_a = REG_ESP;
            default: ;
        endcase
        case (bus.in_icode)
            ICODE_RMMOVL, ICODE_MRMOVL, ICODE_OPL:               src_b = bus.in_rB;
            ICODE_CALL, ICODE_RET, ICODE_PUSHL, ICODE_POPL:      src_b = REG_ESP;
            default: ;
        endcase
        case (bus.in_icode)
            ICODE_RRMOVL, ICODE_IRMOVL, ICODE_OPL:               dst_e = bus.in_rB;
            ICODE_CALL, ICODE_RET, ICODE_PUSHL, ICODE_POPL:      dst_e = REG_ESP;
            default: ;
        endcase
        case (bus.in_icode)
            ICODE_MRMOVL, ICODE_POPL: dst_m = bus.in_rA;
            default: ;
        endcase
    end

    y86_regfile #(.DATA_W(DATA_W), .ESP_INIT(ESP_INIT)) u_regfile (
        .clock     (clock),
        .reset_n   (reset_n),
        .rd_a_id   (src_a),
        .rd_a_data (rd_a),
        .rd_b_id   (src_b),
        .rd_b_data (rd_b),
        .wr_e_id   (bus.wb_dstE),
        .wr_e_data (bus.wb_valE),
        .wr_m_id   (bus.wb_dstM),
        .wr_m_data (bus.wb_valM)
    );

    assign bus.in_ready = !halted_q && (!out_valid_q || bus.out_ready);
    assign capture      = bus.in_valid && bus.in_ready;
    assign out_from_p   = (icode_q == ICODE_JXX) || (icode_q == ICODE_CALL);

    // A stalled entry tracks writebacks so it never leaves with a stale operand.
    always_comb begin
        ref_a = vala_q;
        ref_b = valb_q;
        if (!out_from_p && is_gpr(srca_q)) begin
            if (bus.wb_dstM == srca_q)      ref_a = bus.wb_valM;
            else if (bus.wb_dstE == srca_q) ref_a = bus.wb_valE;
        end
        if (is_gpr(srcb_q)) begin
            if (bus.wb_dstM == srcb_q)      ref_b = bus.wb_valM;
            else if (bus.wb_dstE == srcb_q) ref_b = bus.wb_valE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            err_q       <= 1'b0;
            icode_q     <= '0;
            ifun_q      <= '0;
            valc_q      <= '0;
            valp_q      <= '0;
            vala_q      <= '0;
            valb_q      <= '0;
            srca_q      <= REG_NONE;
            srcb_q      <= REG_NONE;
            dste_q      <= REG_NONE;
            dstm_q      <= REG_NONE;
        end else if (bus.flush) begin
            out_valid_q <= 1'b0;
        end else if (capture) begin
            out_valid_q <= 1'b1;
            icode_q     <= bus.in_icode;
            ifun_q      <= bus.in_ifun;
            valc_q      <= bus.in_valC;
            valp_q      <= bus.in_valP;
            vala_q      <= (bus.in_icode == ICODE_JXX || bus.in_icode == ICODE_CALL)
                           ? bus.in_valP : rd_a;
            valb_q      <= rd_b;
            srca_q      <= src_a;
            srcb_q      <= src_b;
            dste_q      <= dst_e;
            dstm_q      <= dst_m;
            if (bus.in_icode == ICODE_HALT) halted_q <= 1'b1;
            if (bus.in_icode > ICODE_POPL) begin
                halted_q <= 1'b1;
                err_q    <= 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end else if (out_valid_q) begin
            vala_q <= ref_a;
            valb_q <= ref_b;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_icode = icode_q;
    assign bus.out_ifun  = ifun_q;
    assign bus.out_valC  = valc_q;
    assign bus.out_valP  = valp_q;
    assign bus.out_valA  = vala_q;
    assign bus.out_valB  = valb_q;
    assign bus.out_srcA  = srca_q;
    assign bus.out_srcB  = srcb_q;
    assign bus.out_dstE  = dste_q;
    assign bus.out_dstM  = dstm_q;
    assign bus.halted    = halted_q;
    assign bus.err       = err_q;

endmodule
